// File: rtl/rice_pkg.sv
// Shared configuration, FSM state type and zigzag mapping for the Rice encoder.
package rice_pkg;

   localparam int W_DATA  = 16;
   localparam int W_WORD  = 32;
   localparam int W_K     = 5;
   localparam int K_MAX   = W_DATA - 1;
   localparam int FILL_W  = $clog2(2 * W_WORD + 1);
   localparam int NBITS_W = $clog2(W_WORD) + 1;

   typedef enum logic [1:0] {
      IDLE,
      ZEROS,
      TAIL,
      FLUSH
   } state_e;

   // Folds signed residuals onto unsigned codes: 0,-1,1,-2,... -> 0,1,2,3,...
   function automatic logic [W_DATA-1:0] zigzag(input logic signed [W_DATA-1:0] x);
      return (x <<< 1) ^ (x >>> (W_DATA - 1));
   endfunction

endpackage

// File: rtl/rice_bit_packer.sv
// MSB-aligned bit accumulator: appends variable-length fields, pops fixed-width words.
module rice_bit_packer
   import rice_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [W_WORD-1:0]  appBits_i,
   input  logic [NBITS_W-1:0] appLen_i,
   input  logic               appEn_i,
   input  logic               pop_i,
   input  logic               flush_i,
   output logic [W_WORD-1:0]  data_o,
   output logic [NBITS_W-1:0] nbits_o,
   output logic               valid_o,
   output logic               last_o,
   output logic               spaceOk_o
);

   localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(W_WORD);

   logic [2*W_WORD-1:0] acc_q, acc_d, accPopped;
   logic [FILL_W-1:0]   fill_q, fill_d, fillPopped;
   logic                full;

   assign full      = fill_q >= WORD_FILL;
   assign spaceOk_o = fill_q <= WORD_FILL;
   assign valid_o   = full || (flush_i && fill_q != '0);
   assign last_o    = flush_i && fill_q != '0 && fill_q <= WORD_FILL;
   assign data_o    = acc_q[2*W_WORD-1 -: W_WORD];
   assign nbits_o   = full ? NBITS_W'(W_WORD) : NBITS_W'(fill_q);

   // Pop first so a same-cycle append lands directly behind the remaining bits.
   always_comb begin
      accPopped  = acc_q;
      fillPopped = fill_q;
      if (pop_i && valid_o) begin
         if (full) begin
            accPopped  = acc_q << W_WORD;
            fillPopped = fill_q - WORD_FILL;
         end else begin
            accPopped  = '0;
            fillPopped = '0;
         end
      end
      acc_d  = accPopped;
      fill_d = fillPopped;
      if (appEn_i && spaceOk_o) begin
         acc_d  = accPopped | ({appBits_i, {W_WORD{1'b0}}} >> fillPopped);
         fill_d = fillPopped + FILL_W'(appLen_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q  <= '0;
         fill_q <= '0;
      end else begin
         acc_q  <= acc_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/rice_encoder.sv
// Streaming Rice encoder: zigzag, split by k, emit q zeros + '1' + k remainder bits.
module rice_encoder
   import rice_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [W_DATA-1:0]  s_data,
   input  logic [W_K-1:0]     s_k,
   input  logic               s_last,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [W_WORD-1:0]  m_data,
   output logic [NBITS_W-1:0] m_nbits,
   output logic               m_last
);

   state_e              state_q, state_d;
   logic [W_DATA-1:0]   qRem_q, qRem_d;
   logic [W_DATA-1:0]   r_q, r_d;
   logic [W_K-1:0]      k_q, k_d;
   logic                last_q, last_d;
   logic                readyEn_q;

   logic [W_DATA-1:0]   u, qIn, rIn;
   logic [W_K-1:0]      kEff;
   logic [W_WORD-1:0]   appBits, tailWord;
   logic [NBITS_W-1:0]  appLen, zeroLen, tailShift;
   logic                appEn, spaceOk, pkLast, accept;

   assign u       = zigzag(s_data);
   assign kEff    = (s_k > W_K'(K_MAX)) ? W_K'(K_MAX) : s_k;
   assign qIn     = u >> kEff;
   assign rIn     = u & ((W_DATA'(1) << kEff) - W_DATA'(1));
   assign s_ready = readyEn_q && state_q == IDLE && spaceOk;
   assign accept  = s_valid && s_ready;
   assign m_last  = pkLast;

   assign zeroLen   = (qRem_q > W_DATA'(W_WORD)) ? NBITS_W'(W_WORD) : NBITS_W'(qRem_q);
   assign tailShift = NBITS_W'(W_WORD - 1) - NBITS_W'(k_q);
   assign tailWord  = ((W_WORD'(1) << k_q) | W_WORD'(r_q)) << tailShift;

   // Quotient zeros go out in word-sized chunks so huge q never needs a wide shifter.
   always_comb begin
      state_d = state_q;
      qRem_d  = qRem_q;
      r_d     = r_q;
      k_d     = k_q;
      last_d  = last_q;
      appBits = '0;
      appLen  = '0;
      appEn   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               qRem_d  = qIn;
               r_d     = rIn;
               k_d     = kEff;
               last_d  = s_last;
               state_d = (qIn != '0) ? ZEROS : TAIL;
            end
         end
         ZEROS: begin
            appLen = zeroLen;
            appEn  = 1'b1;
            if (spaceOk) begin
               qRem_d = qRem_q - W_DATA'(zeroLen);
               if (qRem_q <= W_DATA'(W_WORD)) state_d = TAIL;
            end
         end
         TAIL: begin
            appBits = tailWord;
            appLen  = NBITS_W'(k_q) + NBITS_W'(1);
            appEn   = 1'b1;
            if (spaceOk) state_d = last_q ? FLUSH : IDLE;
         end
         FLUSH: begin
            if (!m_valid || (m_ready && pkLast)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         qRem_q    <= '0;
         r_q       <= '0;
         k_q       <= '0;
         last_q    <= 1'b0;
         readyEn_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         qRem_q    <= qRem_d;
         r_q       <= r_d;
         k_q       <= k_d;
         last_q    <= last_d;
         readyEn_q <= 1'b1;
      end
   end

   rice_bit_packer uPacker (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .appBits_i (appBits),
      .appLen_i  (appLen),
      .appEn_i   (appEn),
      .pop_i     (m_valid && m_ready),
      .flush_i   (state_q == FLUSH),
      .data_o    (m_data),
      .nbits_o   (m_nbits),
      .valid_o   (m_valid),
      .last_o    (pkLast),
      .spaceOk_o (spaceOk)
   );

endmodule

// File: tb/tb_rice_encoder.sv
// Self-checking bench for rice_encoder: bit-queue reference model plus directed literal words.
module tb_rice_encoder;

   localparam int W_DATA  = 16;
   localparam int W_WORD  = 32;
   localparam int NBITS_W = 6;

   logic               clk;
   logic               rst_n;
   logic               s_valid;
   logic               s_ready;
   logic [W_DATA-1:0]  s_data;
   logic [4:0]         s_k;
   logic               s_last;
   logic               m_valid;
   logic               m_ready;
   logic [W_WORD-1:0]  m_data;
   logic [NBITS_W-1:0] m_nbits;
   logic               m_last;

   rice_encoder dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_k     (s_k),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_nbits (m_nbits),
      .m_last  (m_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          nbits;
      bit          last;
   } word_t;

   int    compared   = 0;
   int    mismatched = 0;
   bit    modelQ[$];
   int    endMark    = -1;
   word_t wordLog[$];

   bit          heldValid = 0;
   logic [31:0] heldData;
   int          heldNbits;
   bit          heldLast;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s", name);
   endtask

   // Reference codeword straight from the arithmetic definition of the code.
   task automatic modelPush(input int x, input int k, input bit last);
      int u, kEff, q, r;
      u    = (x >= 0) ? 2 * x : -2 * x - 1;
      kEff = (k > W_DATA - 1) ? W_DATA - 1 : k;
      q    = u / (1 << kEff);
      r    = u % (1 << kEff);
      for (int i = 0; i < q; i++) modelQ.push_back(1'b0);
      modelQ.push_back(1'b1);
      for (int j = kEff - 1; j >= 0; j--) modelQ.push_back(((r >> j) & 1) != 0);
      if (last) endMark = modelQ.size();
   endtask

   task automatic modelPop(output word_t w);
      int n;
      bit lastW;
      if (endMark < 0 || endMark > W_WORD) begin
         n     = W_WORD;
         lastW = 1'b0;
      end else begin
         n     = endMark;
         lastW = 1'b1;
      end
      w.data  = '0;
      w.nbits = n;
      w.last  = lastW;
      if (modelQ.size() < n) begin
         failNow("model_underflow (DUT emitted a word with no pending bits)");
         modelQ.delete();
      end else begin
         for (int i = 0; i < n; i++) w.data[W_WORD-1-i] = modelQ.pop_front();
      end
      if (endMark >= 0) endMark = lastW ? -1 : endMark - n;
   endtask

   // Single compare process: reset values, hold-under-backpressure, and every accepted word.
   always @(negedge clk) begin
      word_t exp;
      if (!rst_n) begin
         checkOutput("reset_s_ready", s_ready, 0);
         checkOutput("reset_m_valid", m_valid, 0);
         checkOutput("reset_m_data", m_data, 0);
         checkOutput("reset_m_nbits", m_nbits, 0);
         checkOutput("reset_m_last", m_last, 0);
         modelQ.delete();
         endMark   = -1;
         heldValid = 0;
      end else begin
         if (heldValid) begin
            checkOutput("hold_m_valid", m_valid, 1);
            checkOutput("hold_m_data", m_data, heldData);
            checkOutput("hold_m_nbits", m_nbits, heldNbits);
            checkOutput("hold_m_last", m_last, heldLast);
         end
         if (m_valid && m_ready) begin
            modelPop(exp);
            checkOutput("word_data", m_data, exp.data);
            checkOutput("word_nbits", m_nbits, exp.nbits);
            checkOutput("word_last", m_last, exp.last);
            wordLog.push_back('{data: m_data, nbits: int'(m_nbits), last: m_last});
         end
         if (s_valid && s_ready) modelPush(int'($signed(s_data)), int'(s_k), s_last);
         heldValid = m_valid && !m_ready;
         heldData  = m_data;
         heldNbits = int'(m_nbits);
         heldLast  = m_last;
      end
   end

   task automatic applyStimulus(input int x, input int k, input bit last);
      int budget;
      logic [31:0] xv;
      budget  = 0;
      xv      = x;
      s_valid = 1'b1;
      s_data  = xv[15:0];
      s_k     = 5'(k);
      s_last  = last;
      @(negedge clk);
      while (!s_ready && budget < 2000) begin
         budget++;
         @(negedge clk);
      end
      if (!s_ready) failNow("s_ready_timeout");
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic waitWords(input int n);
      int budget;
      budget = 0;
      while (wordLog.size() < n && budget < 3000) begin
         budget++;
         @(negedge clk);
      end
      if (wordLog.size() < n) failNow("word_wait_timeout");
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic checkWord(input int idx, input logic [31:0] data, input int nbits, input bit last);
      if (idx >= wordLog.size()) begin
         failNow("literal_word_missing");
      end else begin
         checkOutput("lit_data", wordLog[idx].data, data);
         checkOutput("lit_nbits", wordLog[idx].nbits, nbits);
         checkOutput("lit_last", wordLog[idx].last, last);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "[TB] simulation watchdog expired");
   end

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_k     = '0;
      s_last  = 1'b0;
      m_ready = 1'b1;

      // Reset and the one-cycle delay before s_ready asserts.
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("s_ready_first_cycle", s_ready, 0);
      @(negedge clk);
      checkOutput("s_ready_after_reset", s_ready, 1);
      @(posedge clk);
      #1;

      $display("[TB] x=3 k=2");
      wordLog.delete();
      applyStimulus(3, 2, 1);
      waitWords(1);
      checkWord(0, 32'h6000_0000, 4, 1);

      $display("[TB] x=0 k=0, x=-1 k=0");
      wordLog.delete();
      applyStimulus(0, 0, 0);
      applyStimulus(-1, 0, 1);
      waitWords(1);
      checkWord(0, 32'hA000_0000, 3, 1);

      $display("[TB] x=40 k=0 long quotient");
      wordLog.delete();
      applyStimulus(40, 0, 1);
      waitWords(3);
      checkWord(0, 32'h0000_0000, 32, 0);
      checkWord(1, 32'h0000_0000, 32, 0);
      checkWord(2, 32'h0000_8000, 17, 1);

      $display("[TB] x=-32768 k=15");
      wordLog.delete();
      applyStimulus(-32768, 15, 1);
      waitWords(1);
      checkWord(0, 32'h7FFF_8000, 17, 1);

      $display("[TB] x=5 k=31 saturates to 15");
      wordLog.delete();
      applyStimulus(5, 31, 1);
      waitWords(1);
      checkWord(0, 32'h800A_0000, 16, 1);

      $display("[TB] backpressure over a stream of x=40 samples");
      wordLog.delete();
      fork
         begin
            for (int i = 0; i < 4; i++) applyStimulus(40, 0, i == 3);
         end
         begin
            repeat (3) @(posedge clk);
            #1 m_ready = 1'b0;
            repeat (20) @(posedge clk);
            @(negedge clk);
            checkOutput("stall_s_ready", s_ready, 0);
            checkOutput("stall_m_valid", m_valid, 1);
            @(posedge clk);
            #1 m_ready = 1'b1;
         end
      join
      waitWords(11);
      checkOutput("stall_word_count", wordLog.size(), 11);
      checkWord(10, 32'h1000_0000, 4, 1);

      $display("[TB] reset in the middle of a codeword");
      wordLog.delete();
      applyStimulus(40, 0, 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checkOutput("post_reset_no_words", wordLog.size(), 0);
      applyStimulus(3, 2, 1);
      waitWords(1);
      checkOutput("post_reset_word_count", wordLog.size(), 1);
      checkWord(0, 32'h6000_0000, 4, 1);

      checkOutput("model_drained", modelQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
